// File: rtl/cpu_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cpu_monitor_pkg
// Shared types and helpers for the cpu_run_monitor block and its trace FIFO.
//   mon_state_t    : monitor FSM states (IDLE, RUN, HALTED), 2-bit encoding
//   trace_entry_t  : trace record {pc, alu, cycle} at the default widths
//   fifo_ptr_w()   : FIFO pointer width (address bits) for a given depth
// -----------------------------------------------------------------------------
package cpu_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } mon_state_t;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TRACE_DEPTH = 16;

  // Address bits needed to index a FIFO of the given (power-of-two) depth.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_TRACE_PTR_W = fifo_ptr_w(DEF_TRACE_DEPTH);

  // Trace record at the default widths; the top re-declares the same layout
  // with its own XLEN/CNT_W parameters so non-default builds stay consistent.
  typedef struct packed {
    logic [DEF_XLEN-1:0]  pc;
    logic [DEF_XLEN-1:0]  alu;
    logic [DEF_CNT_W-1:0] cycle;
  } trace_entry_t;

endpackage

// File: rtl/cpu_run_monitor_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding trace records. Pointers carry one extra wrap bit so
// full and empty can be told apart without a separate occupancy counter.
// No bypass: a record written into an empty FIFO becomes visible next cycle.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   push_i, push_data_i        write request and record
//   push_accept_o              write request is taken this cycle
//   pop_valid_o, pop_ready_i   head handshake; pop on valid && ready
//   pop_data_o                 head record (zero while empty)
//   full_o, empty_o            occupancy flags
// -----------------------------------------------------------------------------
module trace_fifo
  import cpu_monitor_pkg::*;
#(
  parameter int W     = 96,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         push_accept_o,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             pop_s;

  assign empty_o       = (wr_ptr_q == rd_ptr_q);
  assign full_o        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_valid_o   = !empty_o;
  assign pop_s         = pop_valid_o && pop_ready_i;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push_accept_o = push_i && (!full_o || pop_s);
  // Masked head keeps the data outputs at zero after reset and while empty.
  assign pop_data_o    = empty_o ? {W{1'b0}} : mem_q[rd_ptr_q[PTR_W-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {(PTR_W+1){1'b0}};
      rd_ptr_q <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_accept_o) begin
        wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array write; contents are only observed through valid pointers.
  always_ff @(posedge clk_i) begin
    if (push_accept_o) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
// Run-time monitor for the single-cycle risc_v core. While running it counts
// cycles, counts PC-change events (retires), traces each event into a FIFO
// and declares halt once the PC has stayed put for HALT_CYCLES samples.
// Ports:
//   CLK, Reset                 clock, asynchronous active-low reset
//   Enable                     sample only while high
//   ClearHalt                  pulse: leave HALTED, clear counters/flags
//   PcCurrent, AluResult       core nets sampled each RUN cycle
//   TraceValid/Ready           trace head handshake
//   TracePc/Alu/Cycle          trace head record
//   Halted                     high in HALTED
//   CycleCount, RetireCount    RUN cycles / PC-change events since clear
//   DropCount, Overflow        lost trace records (saturating) / sticky flag
// -----------------------------------------------------------------------------
module cpu_run_monitor
  import cpu_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int HALT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             ClearHalt,
  input  logic [XLEN-1:0]  PcCurrent,
  input  logic [XLEN-1:0]  AluResult,
  output logic             TraceValid,
  input  logic             TraceReady,
  output logic [XLEN-1:0]  TracePc,
  output logic [XLEN-1:0]  TraceAlu,
  output logic [CNT_W-1:0] TraceCycle,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] RetireCount,
  output logic [CNT_W-1:0] DropCount,
  output logic             Overflow
);

  localparam int STALL_W = $clog2(HALT_CYCLES + 1);
  localparam int ENTRY_W = 2 * XLEN + CNT_W;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  alu;
    logic [CNT_W-1:0] cycle;
  } entry_t;

  mon_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              halted_q, halted_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
  logic              prev_valid_q, prev_valid_d;

  logic              event_s;
  logic              push_s;
  logic              push_accept_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic              unused_s;
  entry_t            push_entry_s;
  entry_t            head_entry_s;

  // First sample after a clear, or any PC change, is a retire event.
  assign event_s = !prev_valid_q || (PcCurrent != prev_pc_q);

  // Stamp carries the cycle count before this cycle's increment.
  assign push_entry_s = '{pc: PcCurrent, alu: AluResult, cycle: cycle_q};

  // A requested record that the FIFO cannot take is a drop.
  assign drop_s   = push_s && !push_accept_s;
  assign unused_s = full_s ^ empty_s;

  // Next-state logic: FSM transitions, counters, stall detect, trace push.
  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    retire_d     = retire_q;
    drop_d       = drop_q;
    ovf_d        = ovf_q;
    stall_d      = stall_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    push_s       = 1'b0;

    if (ClearHalt) begin
      // Clear takes priority over sampling; FIFO contents are left alone.
      cycle_d      = {CNT_W{1'b0}};
      retire_d     = {CNT_W{1'b0}};
      drop_d       = {CNT_W{1'b0}};
      ovf_d        = 1'b0;
      stall_d      = {STALL_W{1'b0}};
      prev_valid_d = 1'b0;
      case (state_q)
        IDLE:    state_d = Enable ? RUN : IDLE;
        RUN:     state_d = Enable ? RUN : IDLE;
        HALTED:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (Enable) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (!Enable) begin
            // Pause: counters, stall count and prev PC all hold.
            state_d = IDLE;
          end else begin
            cycle_d      = cycle_q + CNT_W'(1);
            prev_pc_d    = PcCurrent;
            prev_valid_d = 1'b1;
            if (event_s) begin
              retire_d = retire_q + CNT_W'(1);
              stall_d  = {STALL_W{1'b0}};
              push_s   = 1'b1;
              state_d  = RUN;
            end else begin
              stall_d = stall_q + STALL_W'(1);
              if (stall_d == STALL_W'(HALT_CYCLES)) begin
                state_d = HALTED;
              end else begin
                state_d = RUN;
              end
            end
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase

      if (drop_s) begin
        drop_d = (&drop_q) ? drop_q : drop_q + CNT_W'(1);
        ovf_d  = 1'b1;
      end else begin
        drop_d = drop_d;
        ovf_d  = ovf_d;
      end
    end

    halted_d = (state_d == HALTED);
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cycle_q      <= {CNT_W{1'b0}};
      retire_q     <= {CNT_W{1'b0}};
      drop_q       <= {CNT_W{1'b0}};
      ovf_q        <= 1'b0;
      halted_q     <= 1'b0;
      stall_q      <= {STALL_W{1'b0}};
      prev_pc_q    <= {XLEN{1'b0}};
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      retire_q     <= retire_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      halted_q     <= halted_d;
      stall_q      <= stall_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i         (CLK),
    .rst_ni        (Reset),
    .push_i        (push_s),
    .push_data_i   (push_entry_s),
    .push_accept_o (push_accept_s),
    .pop_valid_o   (TraceValid),
    .pop_ready_i   (TraceReady),
    .pop_data_o    (head_entry_s),
    .full_o        (full_s),
    .empty_o       (empty_s)
  );

  assign TracePc     = head_entry_s.pc;
  assign TraceAlu    = head_entry_s.alu;
  assign TraceCycle  = head_entry_s.cycle;
  assign Halted      = halted_q;
  assign CycleCount  = cycle_q;
  assign RetireCount = retire_q;
  assign DropCount   = drop_q;
  assign Overflow    = ovf_q;

endmodule
